// File: rtl/fir_xifu_pkg.sv
// Shared types and defaults for the XIF scoreboard: ID width, outstanding limit
// and the per-ID lifecycle state encoding.
package fir_xifu_pkg;

   localparam int X_ID_WIDTH          = 4;
   localparam int MAX_OUTSTANDING_DEF = 4;

   typedef enum logic [1:0] {
      SB_FREE      = 2'd0,
      SB_ISSUED    = 2'd1,
      SB_COMMITTED = 2'd2,
      SB_KILLED    = 2'd3
   } sb_state_t;

endpackage

// File: rtl/fir_xifu_scoreboard_if.sv
// Issue / commit / clear bundle plus status outputs of the XIF scoreboard.
// Issue handshake: an issue is accepted in a cycle where issue_valid_i && issue_ready_o.
interface fir_xifu_scoreboard_if #(
   parameter int X_ID_WIDTH      = fir_xifu_pkg::X_ID_WIDTH,
   parameter int MAX_OUTSTANDING = fir_xifu_pkg::MAX_OUTSTANDING_DEF
) ();
   localparam int X_ID_MAX = 2 ** X_ID_WIDTH;
   localparam int CW       = $clog2(MAX_OUTSTANDING + 1);

   logic                  issue_valid_i;
   logic [X_ID_WIDTH-1:0] issue_id_i;
   logic                  issue_ready_o;
   logic                  commit_valid_i;
   logic [X_ID_WIDTH-1:0] commit_id_i;
   logic                  commit_kill_i;
   logic                  clear_valid_i;
   logic [X_ID_WIDTH-1:0] clear_id_i;
   logic [X_ID_MAX-1:0]   issued_o;
   logic [X_ID_MAX-1:0]   committed_o;
   logic [X_ID_MAX-1:0]   killed_o;
   logic [CW-1:0]         outstanding_o;
   logic                  full_o;
   logic                  empty_o;
   logic                  error_o;

   modport slave (
      input  issue_valid_i, issue_id_i, commit_valid_i, commit_id_i, commit_kill_i,
             clear_valid_i, clear_id_i,
      output issue_ready_o, issued_o, committed_o, killed_o, outstanding_o,
             full_o, empty_o, error_o
   );

   modport master (
      output issue_valid_i, issue_id_i, commit_valid_i, commit_id_i, commit_kill_i,
             clear_valid_i, clear_id_i,
      input  issue_ready_o, issued_o, committed_o, killed_o, outstanding_o,
             full_o, empty_o, error_o
   );
endinterface

// File: rtl/fir_xifu_sb_entry.sv
// Lifecycle FSM for a single XIF instruction ID. o_retire pulses on the cycle
// the entry leaves COMMITTED (clear) or KILLED (automatic) back to FREE.
module fir_xifu_sb_entry
   import fir_xifu_pkg::*;
(
   input  logic      clk_i,
   input  logic      rst_i,
   input  logic      i_issue,
   input  logic      i_commit,
   input  logic      i_kill,
   input  logic      i_clear,
   output sb_state_t o_state,
   output logic      o_retire
);

   sb_state_t r_state;
   sb_state_t w_next;

   always_ff @(posedge clk_i) begin
      if (rst_i) r_state <= SB_FREE;
      else       r_state <= w_next;
   end

   // Events that do not match the current state are dropped here.
   always_comb begin
      w_next   = r_state;
      o_retire = 1'b0;
      case (r_state)
         SB_FREE:      if (i_issue) w_next = SB_ISSUED;
         SB_ISSUED:    if (i_commit) w_next = i_kill ? SB_KILLED : SB_COMMITTED;
         SB_COMMITTED: if (i_clear) begin
            w_next   = SB_FREE;
            o_retire = 1'b1;
         end
         SB_KILLED: begin
            w_next   = SB_FREE;
            o_retire = 1'b1;
         end
         default:      w_next = SB_FREE;
      endcase
   end

   assign o_state = r_state;

endmodule

// File: rtl/fir_xifu_scoreboard.sv
// XIF instruction-ID scoreboard: per-ID lifecycle entries plus the shared
// outstanding counter and issue-ready logic. Optional sticky error flag under
// the FIR_XIFU_SCOREBOARD_ERROR_EN macro.
module fir_xifu_scoreboard
   import fir_xifu_pkg::*;
#(
   parameter int X_ID_WIDTH      = fir_xifu_pkg::X_ID_WIDTH,
   parameter int MAX_OUTSTANDING = fir_xifu_pkg::MAX_OUTSTANDING_DEF
) (
   input logic                 clk_i,
   input logic                 rst_i,
   fir_xifu_scoreboard_if.slave bus
);

   localparam int X_ID_MAX = 2 ** X_ID_WIDTH;
   localparam int CW       = $clog2(MAX_OUTSTANDING + 1);

   sb_state_t           w_state [X_ID_MAX];
   logic [X_ID_MAX-1:0] w_retire;
   logic                w_full;
   logic                w_issue_ready;
   logic                w_issue_fire;
   logic [CW+1:0]       w_ret_sum;
   logic [CW+1:0]       w_cnt_next;
   logic [CW-1:0]       r_cnt;

   assign w_full        = (r_cnt == CW'(MAX_OUTSTANDING));
   assign w_issue_ready = (w_state[bus.issue_id_i] == SB_FREE) && !w_full;
   assign w_issue_fire  = bus.issue_valid_i && w_issue_ready;

   for (genvar g = 0; g < X_ID_MAX; g++) begin : g_entry
      fir_xifu_sb_entry u_entry (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .i_issue (w_issue_fire && (bus.issue_id_i == X_ID_WIDTH'(g))),
         .i_commit(bus.commit_valid_i && (bus.commit_id_i == X_ID_WIDTH'(g))),
         .i_kill  (bus.commit_kill_i),
         .i_clear (bus.clear_valid_i && (bus.clear_id_i == X_ID_WIDTH'(g))),
         .o_state (w_state[g]),
         .o_retire(w_retire[g])
      );
      assign bus.issued_o[g]    = (w_state[g] != SB_FREE);
      assign bus.committed_o[g] = (w_state[g] == SB_COMMITTED);
      assign bus.killed_o[g]    = (w_state[g] == SB_KILLED);
   end

   // A clear and an auto-free of a killed entry can retire in the same cycle.
   always_comb begin
      w_ret_sum = '0;
      for (int i = 0; i < X_ID_MAX; i++) begin
         w_ret_sum = w_ret_sum + {{(CW+1){1'b0}}, w_retire[i]};
      end
      w_cnt_next = {2'b00, r_cnt} + {{(CW+1){1'b0}}, w_issue_fire} - w_ret_sum;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) r_cnt <= '0;
      else       r_cnt <= w_cnt_next[CW-1:0];
   end

   assign bus.issue_ready_o = w_issue_ready;
   assign bus.outstanding_o = r_cnt;
   assign bus.full_o        = w_full;
   assign bus.empty_o       = (r_cnt == '0);

`ifdef FIR_XIFU_SCOREBOARD_ERROR_EN
   logic r_error;
   logic w_err_evt;

   assign w_err_evt =
      (bus.commit_valid_i && (w_state[bus.commit_id_i] != SB_ISSUED))    ||
      (bus.clear_valid_i  && (w_state[bus.clear_id_i]  != SB_COMMITTED)) ||
      (bus.issue_valid_i  && (w_state[bus.issue_id_i]  != SB_FREE));

   always_ff @(posedge clk_i) begin
      if (rst_i)          r_error <= 1'b0;
      else if (w_err_evt) r_error <= 1'b1;
   end

   assign bus.error_o = r_error;
`else
   assign bus.error_o = 1'b0;
`endif

endmodule

// File: doc/fir_xifu_scoreboard.md
FIR_XIFU_SCOREBOARD -- requirements
Module: fir_xifu_scoreboard

Interface
REQ-001 SHALL have parameter X_ID_WIDTH, default 4, meaning width of the XIF instruction ID; X_ID_MAX = 2**X_ID_WIDTH.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, range 1..X_ID_MAX, meaning the maximum number of non-FREE IDs.
REQ-003 SHALL have clk_i, input, 1 bit, as the single clock; all state updates on its rising edge.
REQ-004 SHALL have rst_i, input, 1 bit, as a synchronous, active-high reset.
REQ-005 SHALL have issue_valid_i (input, 1), issue_id_i (input, X_ID_WIDTH) and issue_ready_o (output, 1): the issue handshake from ID.
REQ-006 SHALL have commit_valid_i (input, 1), commit_id_i (input, X_ID_WIDTH) and commit_kill_i (input, 1): the XIF commit interface.
REQ-007 SHALL have clear_valid_i (input, 1) and clear_id_i (input, X_ID_WIDTH): retirement from WB.
REQ-008 SHALL have issued_o, committed_o and killed_o (outputs, X_ID_MAX each): per-ID status vectors feeding ctrl2wb_t and ctrl2ex_t.
REQ-009 SHALL have outstanding_o (output, $clog2(MAX_OUTSTANDING+1)), full_o (output, 1), empty_o (output, 1) and error_o (output, 1).

Function
REQ-010 SHALL keep one state per ID: FREE, ISSUED, COMMITTED or KILLED.
REQ-011 SHALL drive issue_ready_o = (state[issue_id_i]==FREE) && !full_o, combinationally from registered state only.
REQ-012 SHALL move FREE->ISSUED on issue_valid_i && issue_ready_o.
REQ-013 SHALL move ISSUED->COMMITTED on a commit with kill=0, and ISSUED->KILLED on a commit with kill=1.
REQ-014 SHALL move KILLED->FREE unconditionally one cycle after entering KILLED.
REQ-015 SHALL move COMMITTED->FREE on clear_valid_i for that ID.
REQ-016 SHALL ignore a commit to a non-ISSUED ID and a clear to a non-COMMITTED ID (no state change).
REQ-017 SHALL drive the status vectors from state: issued_o[i]=(state!=FREE), committed_o[i]=(state==COMMITTED), killed_o[i]=(state==KILLED).
REQ-018 SHALL update outstanding_o by +1 per accepted issue and -1 per retirement (clear or KILLED->FREE), net per cycle; a simultaneous issue and retirement leaves it unchanged.
REQ-019 SHALL drive full_o=(outstanding_o==MAX_OUTSTANDING) and empty_o=(outstanding_o==0).
REQ-020 SHALL allow issue, commit and clear in the same cycle to different IDs, with all three taking effect.
REQ-021 SHALL block an issue to an ID being cleared in the same cycle (ready from the current state); that issue is accepted the following cycle.
REQ-022 SHALL not change any state on a commit to an ID being issued in the same cycle (the ID is FREE, so the commit is ignored).
REQ-023 SHALL keep status vectors and count consistent when the counter is at MAX_OUTSTANDING and a retirement occurs: the counter decrements and issue_ready_o reasserts the next cycle.

Reset
REQ-024 SHALL, while rst_i is high at a clock edge, set all IDs FREE, outstanding_o=0, error_o=0 and issue_ready_o=1, empty_o=1, full_o=0, and all status vectors 0.
REQ-025 SHALL have reset take precedence over any simultaneous issue, commit or clear, and discard in-flight IDs.

Configuration
REQ-026 SHALL, with FIR_XIFU_SCOREBOARD_ERROR_EN defined, set error_o sticky high on any event ignored per REQ-016 or on issue_valid_i to a non-FREE ID; error_o clears only on reset.
REQ-027 SHALL, without FIR_XIFU_SCOREBOARD_ERROR_EN, tie error_o to 0 and contain no error logic; all other behaviour is identical.

Structure
REQ-028 SHALL place sb_state_t (2-bit enum FREE/ISSUED/COMMITTED/KILLED) and the default MAX_OUTSTANDING constant in fir_xifu_pkg, alongside the existing X_ID_WIDTH.
REQ-029 SHALL implement each per-ID FSM in the sub-module fir_xifu_sb_entry, instantiated X_ID_MAX times; the counter and ready logic stay in the top level.

Verification
REQ-030 SHALL verify the basic lifecycle: issue ID 3 -> issued_o=0x0008; commit ID 3 with kill=0 -> committed_o=0x0008; clear ID 3 -> all vectors 0 and outstanding_o=0.
REQ-031 SHALL verify the kill path: issue ID 5, then commit ID 5 with kill=1 -> killed_o[5]=1 for exactly one cycle, then FREE and outstanding_o=0.
REQ-032 SHALL verify full: with MAX_OUTSTANDING=4, issue IDs 0..3 -> full_o=1 and issue_ready_o=0 for ID 4; clear ID 0 (after its commit) -> the ID 4 issue is accepted the next cycle.
REQ-033 SHALL verify simultaneous events: in one cycle, issue ID 7, commit ID 2 and clear ID 1 -> all take effect and outstanding_o=net +0 relative to the ID 1 retirement.
REQ-034 SHALL verify same-ID clear and issue: clear ID 6 and issue ID 6 in the same cycle -> issue_ready_o=0 that cycle, issue accepted the next cycle, final state ISSUED.
REQ-035 SHALL verify errors and reset: a clear to FREE ID 9 -> error_o=1 only with ERROR_EN; rst_i mid-sequence with 3 IDs in flight -> all outputs at reset values the next cycle.
